// File: rtl/accum_arbiter_if.sv
// Bus between the accumulator arbiter and its environment: session control,
// per-requester sample channels and the accumulator status outputs.
interface accum_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 16
);
  logic                      start;
  logic [15:0]               len;
  logic [N_REQ-1:0]          req_valid;
  logic [N_REQ*DATA_W-1:0]   req_data;
  logic [N_REQ-1:0]          req_ready;
  logic signed [31:0]        acc;
  logic [15:0]               sample_count;
  logic [1:0]                last_grant;
  logic                      busy;
  logic                      done;
  logic                      overflow_flag;
  logic                      underflow_flag;

  modport slave (
    input  start, len, req_valid, req_data,
    output req_ready, acc, sample_count, last_grant, busy, done,
           overflow_flag, underflow_flag
  );

  modport master (
    output start, len, req_valid, req_data,
    input  req_ready, acc, sample_count, last_grant, busy, done,
           overflow_flag, underflow_flag
  );
endinterface

// File: rtl/accum_arbiter.sv
// Round-robin arbiter feeding a saturating-check signed accumulator; a session
// sums len samples and halts on 32-bit overflow or underflow.
module accum_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 16
) (
  input logic            clk,
  input logic            reset,
  accum_arbiter_if.slave bus
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT, S_DONE} state_t;

  state_t             state_q, state_d;
  logic signed [31:0] acc_q, acc_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [15:0]        len_q, len_d;
  logic [1:0]         last_q, last_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;

  logic                     gnt_found;
  logic [PTR_W-1:0]         gnt_idx;
  logic signed [DATA_W-1:0] sample;
  logic [32:0]              sum;
  logic                     sum_ovf, sum_unf;

  // First valid requester at or after ptr_q, wrapping around.
  always_comb begin
    int unsigned cand;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = (32'(ptr_q) + k) % 32'(N_REQ);
      if (!gnt_found && bus.req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = PTR_W'(cand);
      end
    end
  end

  always_comb begin
    sample  = bus.req_data[int'(gnt_idx) * DATA_W +: DATA_W];
    sum     = {acc_q[31], acc_q} + {{(33 - DATA_W){sample[DATA_W-1]}}, sample};
    sum_ovf = ~sum[32] &  sum[31];
    sum_unf =  sum[32] & ~sum[31];
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    last_d  = last_q;
    ptr_d   = ptr_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;

    case (state_q)
      S_RUN: begin
        if (gnt_found) begin
          if (sum_ovf) begin
            ovf_d   = 1'b1;
            state_d = S_HALT;
          end else if (sum_unf) begin
            unf_d   = 1'b1;
            state_d = S_HALT;
          end else begin
            acc_d  = sum[31:0];
            cnt_d  = cnt_q + 16'd1;
            last_d = 2'(gnt_idx);
            ptr_d  = PTR_W'((32'(gnt_idx) + 32'd1) % 32'(N_REQ));
            if (cnt_q + 16'd1 == len_q) state_d = S_DONE;
          end
        end
      end
      default: begin
        // IDLE, HALT and DONE all accept start identically.
        if (bus.start) begin
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          len_d   = bus.len;
          state_d = (bus.len == 16'd0) ? S_DONE : S_RUN;
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      last_q  <= '0;
      ptr_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      last_q  <= last_d;
      ptr_q   <= ptr_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (state_q == S_RUN && gnt_found) bus.req_ready[gnt_idx] = 1'b1;
  end

  assign bus.acc            = acc_q;
  assign bus.sample_count   = cnt_q;
  assign bus.last_grant     = last_q;
  assign bus.busy           = (state_q == S_RUN);
  assign bus.done           = (state_q == S_DONE);
  assign bus.overflow_flag  = ovf_q;
  assign bus.underflow_flag = unf_q;

endmodule

// File: tb/tb_accum_arbiter.sv
// Directed bench for accum_arbiter: a session-level model checked every cycle,
// plus literal expectations for the key scenarios.
module tb_accum_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  logic clk;
  logic reset;

  accum_arbiter_if #(.N_REQ(N), .DATA_W(DW)) bif ();

  accum_arbiter #(.N_REQ(N), .DATA_W(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;
  int grants[$];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    longint acc;
    int     cnt;
    int     len;
    int     last;
    int     ptr;
    bit     run;
    bit     done;
    bit     ovf;
    bit     unf;
  } model_t;

  model_t m;

  function automatic int pick(int ptr, logic [N-1:0] v);
    for (int k = 0; k < N; k++)
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  function automatic model_t step(model_t s, logic st, logic [15:0] ln,
                                  logic [N-1:0] v, logic [N*DW-1:0] d);
    model_t n;
    int g;
    longint total;
    logic signed [DW-1:0] smp;
    n = s;
    n.done = 0;
    if (s.run) begin
      g = pick(s.ptr, v);
      if (g >= 0) begin
        smp   = d[g*DW +: DW];
        total = s.acc + longint'(smp);
        if (total > MAXV) begin
          n.ovf = 1; n.run = 0;
        end else if (total < MINV) begin
          n.unf = 1; n.run = 0;
        end else begin
          n.acc  = total;
          n.cnt  = s.cnt + 1;
          n.last = g;
          n.ptr  = (g + 1) % N;
          if (n.cnt == s.len) begin
            n.run = 0; n.done = 1;
          end
        end
      end
    end else if (st) begin
      n.acc = 0; n.cnt = 0; n.ovf = 0; n.unf = 0;
      n.len = int'(ln);
      if (ln == 16'd0) n.done = 1;
      else n.run = 1;
    end
    return n;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) m <= '{default: 0};
    else       m <= step(m, bif.start, bif.len, bif.req_valid, bif.req_data);
  end

  always @(negedge clk) begin
    int g;
    logic [N-1:0] er;
    if (!reset) begin
      g  = pick(m.ptr, bif.req_valid);
      er = '0;
      if (m.run && g >= 0) er[g] = 1'b1;
      check("req_ready", 32'(bif.req_ready), 32'(er));
      check("acc", bif.acc, 32'(m.acc));
      check("sample_count", 32'(bif.sample_count), 32'(m.cnt));
      check("last_grant", 32'(bif.last_grant), 32'(m.last));
      check("busy", 32'(bif.busy), 32'(m.run));
      check("done", 32'(bif.done), 32'(m.done));
      check("overflow_flag", 32'(bif.overflow_flag), 32'(m.ovf));
      check("underflow_flag", 32'(bif.underflow_flag), 32'(m.unf));
      if (bif.done) n_done++;
      for (int i = 0; i < N; i++)
        if (bif.req_ready[i] && bif.req_valid[i]) grants.push_back(i);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(logic [15:0] l);
    bif.len   = l;
    bif.start = 1'b1;
    tick();
    bif.start = 1'b0;
  endtask

  task automatic wait_done(int max);
    for (int i = 0; i < max && !bif.done; i++) tick();
    check("wait_done_timeout", 32'(bif.done), 32'd1);
  endtask

  task automatic wait_cnt(int target, int max);
    for (int i = 0; i < max && int'(bif.sample_count) != target; i++) tick();
    check("wait_cnt_timeout", 32'(bif.sample_count), 32'(target));
  endtask

  function automatic logic [N*DW-1:0] pack4(logic [31:0] a0, logic [31:0] a1,
                                            logic [31:0] a2, logic [31:0] a3);
    return {a3, a2, a1, a0};
  endfunction

  initial begin
    int d0;
    int exp_seq[8];
    exp_seq = '{0, 1, 2, 3, 0, 1, 2, 3};

    reset         = 1'b1;
    bif.start     = 1'b0;
    bif.len       = '0;
    bif.req_valid = 4'hF;
    bif.req_data  = '0;
    repeat (3) tick();
    check("rst_acc", bif.acc, 32'd0);
    check("rst_cnt", 32'(bif.sample_count), 32'd0);
    check("rst_last", 32'(bif.last_grant), 32'd0);
    check("rst_busy", 32'(bif.busy), 32'd0);
    check("rst_done", 32'(bif.done), 32'd0);
    check("rst_ready", 32'(bif.req_ready), 32'd0);
    check("rst_flags", 32'({bif.overflow_flag, bif.underflow_flag}), 32'd0);
    reset = 1'b0;
    tick();

    // All four valid, len 8: strict rotation, sum 20.
    bif.req_data = pack4(32'd1, 32'd2, 32'd3, 32'd4);
    grants.delete();
    d0 = n_done;
    pulse_start(16'd8);
    wait_done(20);
    check("rr_acc", bif.acc, 32'd20);
    check("rr_cnt", 32'(bif.sample_count), 32'd8);
    check("rr_last", 32'(bif.last_grant), 32'd3);
    check("rr_ngrants", 32'(grants.size()), 32'd8);
    for (int i = 0; i < 8 && i < grants.size(); i++)
      check("rr_order", 32'(grants[i]), 32'(exp_seq[i]));
    tick();
    check("rr_idle_busy", 32'(bif.busy), 32'd0);
    check("rr_idle_done", 32'(bif.done), 32'd0);
    check("rr_done_once", 32'(n_done - d0), 32'd1);

    // Only r2 valid with -5, len 3.
    bif.req_valid = 4'b0100;
    bif.req_data  = pack4(32'd9, 32'd9, 32'hFFFF_FFFB, 32'd9);
    grants.delete();
    pulse_start(16'd3);
    wait_done(10);
    check("r2_acc", bif.acc, 32'hFFFF_FFF1);
    check("r2_last", 32'(bif.last_grant), 32'd2);
    check("r2_ngrants", 32'(grants.size()), 32'd3);
    foreach (grants[i]) check("r2_grant", 32'(grants[i]), 32'd2);
    tick();

    // len = 0 goes straight to DONE without granting.
    bif.req_valid = 4'hF;
    pulse_start(16'd0);
    check("len0_done", 32'(bif.done), 32'd1);
    check("len0_acc", bif.acc, 32'd0);
    check("len0_ready", 32'(bif.req_ready), 32'd0);
    tick();
    check("len0_done_clear", 32'(bif.done), 32'd0);

    // Reset after two of five samples, then a clean restart with an idle gap.
    bif.req_data = pack4(32'd1, 32'd1, 32'd1, 32'd1);
    d0 = n_done;
    pulse_start(16'd5);
    wait_cnt(2, 10);
    reset = 1'b1;
    #1;
    check("mid_rst_acc", bif.acc, 32'd0);
    check("mid_rst_cnt", 32'(bif.sample_count), 32'd0);
    check("mid_rst_busy", 32'(bif.busy), 32'd0);
    check("mid_rst_ready", 32'(bif.req_ready), 32'd0);
    tick();
    reset = 1'b0;
    check("mid_rst_no_done", 32'(n_done - d0), 32'd0);
    tick();
    pulse_start(16'd5);
    tick();
    tick();
    bif.req_valid = 4'h0;
    bif.start     = 1'b1;
    bif.len       = 16'd1;
    tick();
    bif.start = 1'b0;
    tick();
    check("gap_cnt_hold", 32'(bif.sample_count), 32'd2);
    check("gap_busy", 32'(bif.busy), 32'd1);
    bif.req_valid = 4'hF;
    wait_done(20);
    check("restart_acc", bif.acc, 32'd5);
    check("restart_last", 32'(bif.last_grant), 32'd0);
    tick();

    // Overflow: 0x7FFFFFF0 then +0x20 halts with acc held.
    bif.req_valid = 4'b0010;
    bif.req_data  = pack4(32'd0, 32'h7FFF_FFF0, 32'd0, 32'd0);
    d0 = n_done;
    pulse_start(16'd10);
    wait_cnt(1, 10);
    bif.req_data = pack4(32'd0, 32'h0000_0020, 32'd0, 32'd0);
    tick();
    tick();
    check("ovf_flag", 32'(bif.overflow_flag), 32'd1);
    check("ovf_acc", bif.acc, 32'h7FFF_FFF0);
    check("ovf_cnt", 32'(bif.sample_count), 32'd1);
    check("ovf_busy", 32'(bif.busy), 32'd0);
    check("ovf_no_done", 32'(n_done - d0), 32'd0);

    // Underflow restarted from HALT: reach exactly -2^31, next sample halts.
    bif.req_valid = 4'b0001;
    bif.req_data  = pack4(32'h8000_8000, 32'd0, 32'd0, 32'd0);
    pulse_start(16'd10);
    check("unf_ovf_cleared", 32'(bif.overflow_flag), 32'd0);
    wait_cnt(1, 10);
    bif.req_data = pack4(32'hFFFF_8000, 32'd0, 32'd0, 32'd0);
    wait_cnt(2, 10);
    check("unf_min_acc", bif.acc, 32'h8000_0000);
    check("unf_min_flag", 32'(bif.underflow_flag), 32'd0);
    tick();
    check("unf_flag", 32'(bif.underflow_flag), 32'd1);
    check("unf_acc", bif.acc, 32'h8000_0000);
    check("unf_cnt", 32'(bif.sample_count), 32'd2);
    check("unf_busy", 32'(bif.busy), 32'd0);
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
